lpf_mc: RTL and testbench

- Multi-channel, multi-order, time-multiplexed first-order IIR low-pass bank.
- One shared shift/add datapath serves CHANNELS independent filters, each a cascade of ORDER identical one-pole sections. Per-channel, per-stage state is held in registers.
- Used for smoothing multiple sensor/pitch/volume streams where one lpf per stream would waste logic.
- Adds runtime cutoff (shift), signed/unsigned mode, fractional guard bits, valid/ready handshake and synchronous clear.

---
 rtl/lpf_mc.sv | 179 +++++++++++++++++
 tb/tb_lpf_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_mc.sv
// lpf_mc -- time-multiplexed bank of cascaded one-pole IIR low-pass filters.
//
// One shared shift/add datapath serves CHANNELS independent filters. Each
// filter is ORDER identical one-pole sections in cascade. Each accepted
// sample is processed one section per cycle:
//   hp    = x - s                    (S+1 bits, signed)
//   s_new = s + (hp >>> shr)         (truncated to S = DATA_W+FRAC_W bits)
// The state word carries FRAC_W guard bits below the data LSb.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active high
//   clr_i        synchronous clear of all filter state and the sequencer
//   shr_i        cutoff shift, sampled on accept
//   in_valid_i   input sample valid
//   in_ready_o   block can accept a sample (low while busy or clearing)
//   in_ch_i      channel of the input sample
//   in_data_i    input sample
//   out_valid_o  one-cycle result strobe
//   out_ch_o     channel of the result (held between strobes)
//   out_data_o   filtered result (held between strobes)
module lpf_mc #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int ORDER    = 2,
  parameter int FRAC_W   = 8,
  parameter int SHR_W    = 4,
  parameter int SIGNED   = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [SHR_W-1:0]  shr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CH_W-1:0]   in_ch_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [DATA_W-1:0] out_data_o
);

  localparam int S   = DATA_W + FRAC_W;
  localparam int K_W = (ORDER > 1) ? $clog2(ORDER) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [SHR_W-1:0]    shr_reg;
  logic [K_W-1:0]      k_reg;
  logic [S-1:0]        s_reg [CHANNELS][ORDER];
  logic [DATA_W-1:0]   out_data_reg;
  logic [CH_W-1:0]     out_ch_reg;

  logic                accept;
  logic                ch_ok;
  logic                last_stage;
  logic [S-1:0]        cur_s;
  logic [S-1:0]        prev_s;
  logic [S-1:0]        x_val;
  logic [S-1:0]        s_new;
  logic                x_msb;
  logic                s_msb;
  logic signed [S:0]   x_ext;
  logic signed [S:0]   s_ext;
  logic signed [S:0]   hp;
  logic signed [S:0]   hp_sh;

  // One extra bit so the comparison still means something when CHANNELS is
  // a power of two (then every index is in range).
  assign ch_ok      = {1'b0, in_ch_i} < (CH_W+1)'(CHANNELS);
  assign in_ready_o = (state_reg == IDLE) && !clr_i;
  assign accept     = in_valid_i && in_ready_o;
  assign last_stage = (int'(k_reg) == ORDER - 1);

  // Section datapath: select the current state word and the section input.
  // Section k>0 takes the state just written by section k-1 for this same
  // sample, which is already in s_reg one cycle later.
  always_comb begin
    cur_s  = '0;
    prev_s = '0;
    x_val  = '0;
    x_msb  = 1'b0;
    s_msb  = 1'b0;
    x_ext  = '0;
    s_ext  = '0;
    hp     = '0;
    hp_sh  = '0;
    s_new  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int j = 0; j < ORDER; j++) begin
        if (int'(ch_reg) == c && int'(k_reg) == j)     cur_s  = s_reg[c][j];
        if (int'(ch_reg) == c && int'(k_reg) == j + 1) prev_s = s_reg[c][j];
      end
    end
    x_val = (k_reg == '0) ? (S'(data_reg) << FRAC_W) : prev_s;
    x_msb = (SIGNED != 0) ? x_val[S-1] : 1'b0;
    s_msb = (SIGNED != 0) ? cur_s[S-1] : 1'b0;
    x_ext = {x_msb, x_val};
    s_ext = {s_msb, cur_s};
    hp    = x_ext - s_ext;
    // Arithmetic shift floors toward -inf, so the state lands between s and x
    // and never needs saturation.
    hp_sh = hp >>> shr_reg;
    s_new = S'(s_ext + hp_sh);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept && ch_ok) state_next = RUN;
      RUN: begin
        if (clr_i)           state_next = IDLE;
        else if (last_stage) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ch_reg   <= '0;
      data_reg <= '0;
      shr_reg  <= '0;
      k_reg    <= '0;
    end else if (accept) begin
      ch_reg   <= in_ch_i;
      data_reg <= in_data_i;
      shr_reg  <= shr_i;
      k_reg    <= '0;
    end else if (state_reg == RUN) begin
      k_reg    <= k_reg + K_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int j = 0; j < ORDER; j++)
          s_reg[c][j] <= '0;
    end else if (clr_i) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int j = 0; j < ORDER; j++)
          s_reg[c][j] <= '0;
    end else if (state_reg == RUN) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int j = 0; j < ORDER; j++)
          if (int'(ch_reg) == c && int'(k_reg) == j) s_reg[c][j] <= s_new;
    end
  end

  // Result registers load only on a completed last section, so they hold
  // their value across aborted samples and idle periods.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_reg <= '0;
      out_ch_reg   <= '0;
    end else if (state_reg == RUN && last_stage && !clr_i) begin
      out_data_reg <= s_new[S-1:FRAC_W];
      out_ch_reg   <= ch_reg;
    end
  end

  // By DONE the result is fully committed, so the strobe is not withdrawn by
  // a clear arriving in that cycle.
  assign out_valid_o = (state_reg == DONE);
  assign out_data_o  = out_data_reg;
  assign out_ch_o    = out_ch_reg;

endmodule

// File: tb/tb_lpf_mc.sv
module tb_lpf_mc;

  localparam int ORDER = 2;
  localparam int NCH   = 3;
  localparam int FA    = 4;   // guard bits, signed instance A
  localparam int FB    = 0;   // guard bits, unsigned instance B

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  shr = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [15:0] in_data = '0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [1:0]  out_ch_a, out_ch_b;
  logic [15:0] out_data_a, out_data_b;

  always #5 clk = ~clk;

  lpf_mc #(.DATA_W(16), .CHANNELS(NCH), .ORDER(ORDER), .FRAC_W(FA),
           .SHR_W(4), .SIGNED(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .shr_i(shr),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_ch_i(in_ch),
    .in_data_i(in_data), .out_valid_o(out_valid_a), .out_ch_o(out_ch_a),
    .out_data_o(out_data_a));

  lpf_mc #(.DATA_W(16), .CHANNELS(NCH), .ORDER(ORDER), .FRAC_W(FB),
           .SHR_W(4), .SIGNED(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .shr_i(shr),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_ch_i(in_ch),
    .in_data_i(in_data), .out_valid_o(out_valid_b), .out_ch_o(out_ch_b),
    .out_data_o(out_data_b));

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  longint      ma[NCH][ORDER];
  longint      mb[NCH][ORDER];
  logic [15:0] hold_a = '0, hold_b = '0;
  logic [1:0]  hold_ch_a = '0, hold_ch_b = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_low = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // floor(v / 2^sh)
  function automatic longint fshift(input longint v, input int sh);
    longint p;
    p = longint'(1) << sh;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  task automatic model_zero();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < ORDER; k++) begin
        ma[c][k] = 0;
        mb[c][k] = 0;
      end
  endtask

  // Each section moves its state a 2^-shr fraction of the way toward its
  // input, rounding down; the cascade feeds each new state to the next section.
  task automatic model_step(input int ch, input logic [15:0] d, input int sh,
                            output logic [15:0] oa, output logic [15:0] ob);
    longint x, s;
    x = longint'($signed(d)) * (longint'(1) << FA);
    for (int k = 0; k < ORDER; k++) begin
      s = ma[ch][k];
      s = s + fshift(x - s, sh);
      ma[ch][k] = s;
      x = s;
    end
    oa = 16'(fshift(x, FA));
    x = longint'(d) * (longint'(1) << FB);
    for (int k = 0; k < ORDER; k++) begin
      s = mb[ch][k];
      s = s + fshift(x - s, sh);
      mb[ch][k] = s;
      x = s;
    end
    ob = 16'(fshift(x, FB));
  endtask

  // abort: 0 none, 1 clr during RUN, 2 async reset during RUN.
  // Called and returns at a falling edge; in_valid is left as driven so the
  // next call may present a sample while the block is still busy.
  task automatic send(input logic [1:0] ch, input logic [15:0] d,
                      input logic [3:0] sh, input int abort, input bit use_c,
                      input logic [15:0] ca, input logic [15:0] cb);
    int          lowcnt;
    int          dly;
    bit          good;
    logic [15:0] oa, ob;
    exp_t        e;
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    shr      = sh;
    #1;
    lowcnt = 0;
    while (!in_ready_a && lowcnt < 40) begin
      lowcnt++;
      @(negedge clk);
      #1;
    end
    if (!in_ready_a) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    chk("ready_low_cycles", lowcnt, exp_low);
    good = (int'(ch) < NCH);
    if (good && abort == 0) begin
      model_step(int'(ch), d, int'(sh), oa, ob);
      e.ch = ch; e.cyc = cyc + ORDER + 1;
      e.d = use_c ? ca : oa; q_a.push_back(e);
      e.d = use_c ? cb : ob; q_b.push_back(e);
    end
    $display("tx ch=%0d data=%0d shr=%0d abort=%0d exp_a=%0d exp_b=%0d", ch, d, sh,
             abort, (good && abort == 0) ? (use_c ? ca : oa) : 16'd0,
             (good && abort == 0) ? (use_c ? cb : ob) : 16'd0);
    @(posedge clk);
    @(negedge clk);
    if (abort == 1) begin
      in_valid = 1'b0;
      dly = $urandom_range(1, ORDER);
      repeat (dly - 1) @(negedge clk);
      clr = 1'b1;
      #1;
      chk("ready_during_clr", in_ready_a, 0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("ready_after_clr", in_ready_a, 1);
      model_zero();
      exp_low = 0;
    end else if (abort == 2) begin
      in_valid = 1'b0;
      rst = 1'b1;
      q_a.delete(); q_b.delete();
      model_zero();
      hold_a = '0; hold_b = '0; hold_ch_a = '0; hold_ch_b = '0;
      #1;
      chk("rst_ready", in_ready_a, 1);
      chk("rst_valid", out_valid_a, 0);
      chk("rst_data_a", out_data_a, 0);
      chk("rst_data_b", out_data_b, 0);
      chk("rst_ch", out_ch_a, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_low = 0;
    end else begin
      exp_low = good ? ORDER + 1 : 0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    exp_low = (exp_low > n) ? exp_low - n : 0;
  endtask

  // Monitor: pops expected results whenever a result strobe appears and
  // checks that outputs hold between strobes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) continue;
      if (out_valid_a) begin
        if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
        else begin
          e = q_a.pop_front();
          chk("a_data", out_data_a, e.d);
          chk("a_ch", out_ch_a, e.ch);
          chk("a_latency", cyc, e.cyc);
          hold_a = e.d; hold_ch_a = e.ch;
        end
      end else begin
        chk("a_hold", {out_ch_a, out_data_a}, {hold_ch_a, hold_a});
      end
      if (out_valid_b) begin
        if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
        else begin
          e = q_b.pop_front();
          chk("b_data", out_data_b, e.d);
          chk("b_ch", out_ch_b, e.ch);
          chk("b_latency", cyc, e.cyc);
          hold_b = e.d; hold_ch_b = e.ch;
        end
      end else begin
        chk("b_hold", {out_ch_b, out_data_b}, {hold_ch_b, hold_b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ch;
    logic [15:0] d;
    logic [3:0]  sh;
    int          r;
    model_zero();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", in_ready_a, 1);
    chk("reset_valid_a", out_valid_a, 0);
    chk("reset_valid_b", out_valid_b, 0);
    chk("reset_data_a", out_data_a, 0);
    chk("reset_ch_b", out_ch_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Step on ch0, shr=1: cascade gives 50 then 100.
    send(2'd0, 16'd200, 4'd1, 0, 1'b1, 16'd50, 16'd50);
    send(2'd0, 16'd200, 4'd1, 0, 1'b1, 16'd100, 16'd100);
    // Preload ch1 by pass-through, then let it decay toward zero.
    send(2'd1, -16'sd100, 4'd0, 0, 1'b1, -16'sd100, 16'hFF9C);
    for (int i = 0; i < 8; i++) send(2'd1, 16'd0, 4'd2, 0, 1'b0, '0, '0);
    // Out-of-range channel: accepted, no result, no state change.
    send(2'd3, 16'd1234, 4'd1, 0, 1'b0, '0, '0);
    send(2'd0, 16'd200, 4'd1, 0, 1'b0, '0, '0);
    // Interleaved opposite-sign channels.
    for (int i = 0; i < 6; i++) begin
      send(2'd0, 16'd1000, 4'd1, 0, 1'b0, '0, '0);
      send(2'd2, -16'sd1000, 4'd1, 0, 1'b0, '0, '0);
    end
    idle(1);
    // Clear in flight, then a fresh step from zero.
    send(2'd2, 16'd500, 4'd3, 1, 1'b0, '0, '0);
    send(2'd0, 16'd200, 4'd1, 0, 1'b1, 16'd50, 16'd50);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 99);
      ch = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      sh = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(0, 4));
      if (r < 5)      send(2'(int'(ch) % NCH), d, sh, 1, 1'b0, '0, '0);
      else if (r < 7) send(2'(int'(ch) % NCH), d, sh, 2, 1'b0, '0, '0);
      else            send(ch, d, sh, 0, 1'b0, '0, '0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 5));
    end

    // Async reset during RUN, then restart from zero state.
    send(2'd1, 16'd700, 4'd1, 2, 1'b0, '0, '0);
    send(2'd0, 16'd200, 4'd1, 0, 1'b1, 16'd50, 16'd50);
    idle(10);
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
